cam_capture: RTL and testbench

- Write-side counterpart of the VGA frame-buffer reader.
- Samples the OV7670 parallel bus (VSYNC, HREF, D[7:0]) in the camera pixel-clock domain.
- Assembles two-byte RGB444 pixels (xR GB byte order) and issues single-cycle writes into the dual-port BRAM frame buffer at a linear address, 0 to IMG_WIDTH*IMG_HEIGHT-1.
- Skips the first frames after reset so the sensor can settle, and reports frame completion and overflow.

---
 rtl/cam_capture.sv | 134 +++++++++++++
 tb/tb_cam_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture.sv
// OV7670 parallel-bus capture: assembles xR/GB byte pairs into RGB444 pixels and
// writes them linearly into the frame buffer, skipping settle frames after reset.
module cam_capture #(
   parameter int IMG_WIDTH   = 160,
   parameter int IMG_HEIGHT  = 148,
   parameter int SKIP_FRAMES = 2,
   parameter int ADDR_W      = 19
) (
   input  logic              i_pclk,
   input  logic              i_rst_pclk,
   input  logic              i_cam_vsync,
   input  logic              i_cam_href,
   input  logic [7:0]        i_cam_data,
   output logic [ADDR_W-1:0] o_pix_addr,
   output logic [11:0]       o_pix_data,
   output logic              o_pix_wr,
   output logic              o_frame_done,
   output logic [7:0]        o_frame_cnt,
   output logic              o_overflow
);

   localparam logic [ADDR_W-1:0] L_MAX  = ADDR_W'(IMG_WIDTH * IMG_HEIGHT);
   localparam logic [3:0]        L_SKIP = 4'(SKIP_FRAMES);

   if ((64'(IMG_WIDTH) * 64'(IMG_HEIGHT)) >= (64'd1 << ADDR_W)) begin : g_addr_chk
      $error("cam_capture: IMG_WIDTH*IMG_HEIGHT does not fit in ADDR_W bits");
   end

   typedef enum logic [1:0] {
      S_SKIP,
      S_WAIT,
      S_CAPTURE
   } state_t;

   state_t     r_state;
   logic       r_vsync;
   logic       r_vsync_d;
   logic       r_href;
   logic [7:0] r_data;
   logic [3:0] r_skip_cnt;
   logic       r_seen_start;
   logic       r_phase;
   logic [3:0] r_red;

   logic w_fstart;
   logic w_fend;
   logic w_byte_ok;

   assign w_fstart  = r_vsync_d & ~r_vsync;
   assign w_fend    = ~r_vsync_d & r_vsync;
   assign w_byte_ok = r_href & ~r_vsync;

   always_ff @(posedge i_pclk or posedge i_rst_pclk) begin
      if (i_rst_pclk) begin
         r_vsync   <= 1'b0;
         r_vsync_d <= 1'b0;
         r_href    <= 1'b0;
         r_data    <= 8'h00;
      end else begin
         r_vsync   <= i_cam_vsync;
         r_vsync_d <= r_vsync;
         r_href    <= i_cam_href;
         r_data    <= i_cam_data;
      end
   end

   always_ff @(posedge i_pclk or posedge i_rst_pclk) begin
      if (i_rst_pclk) begin
         r_state      <= S_SKIP;
         r_skip_cnt   <= 4'd0;
         r_seen_start <= 1'b0;
         r_phase      <= 1'b0;
         r_red        <= 4'h0;
         o_pix_addr   <= '0;
         o_pix_data   <= 12'h000;
         o_pix_wr     <= 1'b0;
         o_frame_done <= 1'b0;
         o_frame_cnt  <= 8'd0;
         o_overflow   <= 1'b0;
      end else begin
         o_pix_wr     <= 1'b0;
         o_overflow   <= 1'b0;
         o_frame_done <= 1'b0;
         if (o_pix_wr && (o_pix_addr != L_MAX))
            o_pix_addr <= o_pix_addr + 1'b1;

         case (r_state)
            S_SKIP: begin
               r_phase <= 1'b0;
               // only frames whose start was seen after reset count as settled
               if (r_skip_cnt == L_SKIP)
                  r_state <= S_WAIT;
               else if (w_fstart)
                  r_seen_start <= 1'b1;
               else if (w_fend && r_seen_start)
                  r_skip_cnt <= r_skip_cnt + 4'd1;
            end
            S_WAIT: begin
               r_phase <= 1'b0;
               if (w_fstart) begin
                  r_state    <= S_CAPTURE;
                  o_pix_addr <= '0;
               end
            end
            S_CAPTURE: begin
               if (w_fend) begin
                  o_frame_done <= 1'b1;
                  o_frame_cnt  <= o_frame_cnt + 8'd1;
                  o_pix_addr   <= '0;
                  r_phase      <= 1'b0;
                  r_state      <= S_WAIT;
               end else if (w_byte_ok) begin
                  if (!r_phase) begin
                     r_red   <= r_data[3:0];
                     r_phase <= 1'b1;
                  end else begin
                     r_phase <= 1'b0;
                     if (o_pix_addr < L_MAX) begin
                        o_pix_wr   <= 1'b1;
                        o_pix_data <= {r_red, r_data};
                     end else begin
                        o_overflow <= 1'b1;
                     end
                  end
               end else begin
                  r_phase <= 1'b0;
               end
            end
            default: r_state <= S_SKIP;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture on a 4x2 buffer with two skipped frames.
module tb_cam_capture;

   localparam int W    = 4;
   localparam int H    = 2;
   localparam int SKIP = 2;
   localparam int AW   = 19;
   localparam int MAXA = W * H;

   logic          clk = 1'b0;
   logic          rst;
   logic          vsync;
   logic          href;
   logic [7:0]    data;
   logic [AW-1:0] o_pix_addr;
   logic [11:0]   o_pix_data;
   logic          o_pix_wr;
   logic          o_frame_done;
   logic [7:0]    o_frame_cnt;
   logic          o_overflow;

   cam_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SKIP_FRAMES(SKIP), .ADDR_W(AW)) dut (
      .i_pclk       (clk),
      .i_rst_pclk   (rst),
      .i_cam_vsync  (vsync),
      .i_cam_href   (href),
      .i_cam_data   (data),
      .o_pix_addr   (o_pix_addr),
      .o_pix_data   (o_pix_data),
      .o_pix_wr     (o_pix_wr),
      .o_frame_done (o_frame_done),
      .o_frame_cnt  (o_frame_cnt),
      .o_overflow   (o_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;   // 0 write, 1 overflow, 2 frame done
      logic [AW-1:0] addr;
      logic [11:0] pix;
      int          cyc;
      logic [7:0]  cnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   n_wr = 0;

   int   m_skip;
   int   m_addr;
   int   m_cnt;
   bit   m_cap;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic sb_pop(input int kind);
      exp_t e;
      chk("sb_avail", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("sb_kind", 32'(kind), 32'(e.kind));
         if (kind == 0) begin
            chk("wr_addr", 32'(o_pix_addr), 32'(e.addr));
            chk("wr_data", 32'(o_pix_data), 32'(e.pix));
         end
         if (kind < 2) chk("pix_latency", 32'(cyc), 32'(e.cyc));
         if (kind == 2) chk("frame_cnt", 32'(o_frame_cnt), 32'(e.cnt));
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (o_pix_wr) begin
            n_wr++;
            sb_pop(0);
         end
         if (o_overflow) sb_pop(1);
         if (o_frame_done) sb_pop(2);
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 32'({o_pix_wr, o_overflow, o_frame_done, o_frame_cnt}), 32'd0);
      chk({tag, "_addr"}, 32'(o_pix_addr), 32'd0);
      chk({tag, "_data"}, 32'(o_pix_data), 32'd0);
   endtask

   task automatic idle(input int n, input logic vs, input logic hr);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         vsync = vs;
         href  = hr;
         data  = 8'($urandom);
      end
   endtask

   // returns 1 if the frame was aborted by a reset
   task automatic do_line(input int nbytes, input bit directed, input int abort_at,
                          input int wr0, output bit aborted);
      logic [7:0] hi;
      logic [7:0] b;
      exp_t e;
      aborted = 1'b0;
      hi = 8'h00;
      for (int i = 0; i < nbytes; i++) begin
         b = 8'($urandom);
         if (directed && i == 0) b = 8'h0A;
         if (directed && i == 1) b = 8'h5C;
         @(negedge clk);
         vsync = 1'b0;
         href  = 1'b1;
         data  = b;
         if (i % 2 == 0) begin
            hi = b;
         end else if (m_cap) begin
            e.addr = AW'(m_addr);
            e.pix  = {hi[3:0], b};
            e.cyc  = cyc + 2;
            e.cnt  = 8'd0;
            e.kind = (m_addr < MAXA) ? 0 : 1;
            if (m_addr < MAXA) m_addr++;
            q.push_back(e);
         end
         if (abort_at > 0 && (n_wr - wr0) >= abort_at) begin
            #2 rst = 1'b1;
            #1 chk_zero("rst_async");
            q.delete();
            idle(3, 1'b0, 1'b0);
            rst = 1'b0;
            m_skip = SKIP;
            m_cnt  = 0;
            aborted = 1'b1;
            return;
         end
      end
      idle(4, 1'b0, 1'b0);
   endtask

   task automatic do_frame(input int nlines, input int nb_first, input int nb,
                           input bit directed, input int abort_at);
      exp_t e;
      bit   ab;
      int   wr0;
      wr0    = n_wr;
      m_cap  = (m_skip == 0);
      m_addr = 0;
      idle(3, 1'b1, 1'b1);
      idle(3, 1'b0, 1'b0);
      for (int l = 0; l < nlines; l++) begin
         do_line((l == 0) ? nb_first : nb, directed && (l == 0), abort_at, wr0, ab);
         if (ab) return;
      end
      if (m_cap) begin
         chk("addr_pre_end", 32'(o_pix_addr), 32'(m_addr));
         m_cnt++;
         e.kind = 2;
         e.addr = '0;
         e.pix  = 12'h000;
         e.cyc  = 0;
         e.cnt  = 8'(m_cnt);
         q.push_back(e);
      end else begin
         m_skip--;
      end
      idle(5, 1'b1, 1'b0);
      if (m_cap) begin
         chk("addr_post_end", 32'(o_pix_addr), 32'd0);
         chk("sb_drained", 32'(q.size()), 32'd0);
         chk("frame_wr_count", 32'(n_wr - wr0), 32'(m_addr));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst   = 1'b1;
      vsync = 1'b0;
      href  = 1'b0;
      data  = 8'h00;
      m_skip = SKIP;
      m_cnt  = 0;
      m_addr = 0;
      m_cap  = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      idle(2, 1'b0, 1'b0);

      // two skipped frames then a captured one starting with 0x0A,0x5C
      do_frame(2, 8, 8, 1'b0, 0);
      do_frame(2, 8, 8, 1'b0, 0);
      do_frame(2, 8, 8, 1'b1, 0);
      chk("cnt_after_first", 32'(o_frame_cnt), 32'd1);

      // odd-length line realigns on the next line
      do_frame(2, 7, 8, 1'b0, 0);
      // overflow: 12 pixels into an 8-pixel buffer
      do_frame(3, 8, 8, 1'b0, 0);
      // short frame
      do_frame(1, 8, 8, 1'b0, 0);
      chk("cnt_after_short", 32'(o_frame_cnt), 32'd4);

      // reset after the third write, then two skipped frames and capture again
      do_frame(2, 8, 8, 1'b0, 3);
      idle(2, 1'b0, 1'b0);
      chk_zero("post_rst");
      do_frame(2, 8, 8, 1'b0, 0);
      do_frame(2, 8, 8, 1'b0, 0);
      do_frame(2, 8, 8, 1'b0, 0);
      chk("cnt_after_rst", 32'(o_frame_cnt), 32'd1);

      idle(4, 1'b1, 1'b0);
      chk("sb_final", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
